calendar_date_counter: RTL and testbench

- Sequential day/month/year calendar counter; direct downstream consumer of the leap-by-4 detector.
- The registered `year` output drives the external leap detector; its `leap4` result returns here to set February's length when the date advances.
- Provides the date registers and day-of-year index for calendar and date-stamping logic.

---
 rtl/calendar_date_counter.sv | 163 ++++++++++++++++
 tb/tb_calendar_date_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/calendar_date_counter.sv
// -----------------------------------------------------------------------------
// calendar_date_counter
//
// Day/month/year calendar counter with a running day-of-year index. The
// registered `year` output feeds an external divisible-by-4 leap detector whose
// result comes back on `leap4` and sets February's length when the date
// advances. Loads carry their own leap check, derived from `load_year`.
//
// Optional build macro:
//   LEAP_CENTURY_EN - Gregorian century correction. Years divisible by 100
//                     but not by 400 are not leap. The mod-100/400 test is
//                     computed internally from `year` (advance) and from
//                     `load_year` (load).
//
// Ports:
//   clock       in   system clock, all state updates on the rising edge
//   reset       in   synchronous, active-high reset (highest priority)
//   tick        in   advance the date by one day
//   load        in   load load_year/load_month/load_day (wins over tick)
//   load_year   in   [YEAR_W-1:0] year to load
//   load_month  in   [3:0] month to load, 1..12
//   load_day    in   [4:0] day to load, 1..31
//   leap4       in   1 = current `year` is divisible by 4
//   year        out  [YEAR_W-1:0] current year
//   month       out  [3:0] current month, 1..12
//   day         out  [4:0] current day of month, 1..31
//   doy         out  [8:0] day of year, 1..366
//   new_year    out  one-cycle pulse after a Dec 31 -> Jan 1 rollover
//   year_wrap   out  one-cycle pulse after year rolls from max to 0
//   load_err    out  one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module calendar_date_counter #(
   parameter int YEAR_W     = 11,
   parameter int START_YEAR = 2000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              tick,
   input  logic              load,
   input  logic [YEAR_W-1:0] load_year,
   input  logic [3:0]        load_month,
   input  logic [4:0]        load_day,
   input  logic              leap4,
   output logic [YEAR_W-1:0] year,
   output logic [3:0]        month,
   output logic [4:0]        day,
   output logic [8:0]        doy,
   output logic              new_year,
   output logic              year_wrap,
   output logic              load_err
);

   // Days in month m; only meaningful for m in 1..12.
   function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
      case (m)
         4'd2:                       month_len = leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:    month_len = 5'd30;
         default:                    month_len = 5'd31;
      endcase
   endfunction

   // Days in a non-leap year preceding the first of month m.
   function automatic logic [8:0] days_before(input logic [3:0] m);
      case (m)
         4'd2:    days_before = 9'd31;
         4'd3:    days_before = 9'd59;
         4'd4:    days_before = 9'd90;
         4'd5:    days_before = 9'd120;
         4'd6:    days_before = 9'd151;
         4'd7:    days_before = 9'd181;
         4'd8:    days_before = 9'd212;
         4'd9:    days_before = 9'd243;
         4'd10:   days_before = 9'd273;
         4'd11:   days_before = 9'd304;
         4'd12:   days_before = 9'd334;
         default: days_before = 9'd0;
      endcase
   endfunction

   logic       adv_leap;   // leap flag for the currently registered year
   logic       ld_leap;    // leap flag for the year being loaded
   logic [4:0] cur_len;
   logic [4:0] ld_len;
   logic       ld_ok;
   logic [8:0] ld_doy;

`ifdef LEAP_CENTURY_EN
   // Divisible-by-400 is always leap; other multiples of 100 never are;
   // everything else falls back to the divisible-by-4 answer.
   function automatic logic century_leap(input logic [YEAR_W-1:0] y, input logic by4);
      int unsigned yi;
      yi = 32'(y);
      if (yi % 400 == 0)
         century_leap = 1'b1;
      else if (yi % 100 == 0)
         century_leap = 1'b0;
      else
         century_leap = by4;
   endfunction

   assign adv_leap = century_leap(year, leap4);
   assign ld_leap  = century_leap(load_year, load_year[1:0] == 2'b00);
`else
   assign adv_leap = leap4;
   assign ld_leap  = (load_year[1:0] == 2'b00);
`endif

   assign cur_len = month_len(month, adv_leap);
   assign ld_len  = month_len(load_month, ld_leap);

   assign ld_ok = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                  (load_day   >= 5'd1) && (load_day   <= ld_len);

   // The leap day only shifts doy for dates after February.
   assign ld_doy = days_before(load_month) + {4'd0, load_day} +
                   {8'd0, (ld_leap && (load_month > 4'd2))};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create order-dependent
   // behaviour between the fields.
   always_ff @(posedge clock) begin
      // Pulses default low and are raised only in the cycle that causes them.
      new_year  <= 1'b0;
      year_wrap <= 1'b0;
      load_err  <= 1'b0;

      if (reset) begin
         year  <= YEAR_W'(START_YEAR);
         month <= 4'd1;
         day   <= 5'd1;
         doy   <= 9'd1;
      end else if (load) begin
         // A load always consumes the cycle; a simultaneous tick is dropped
         // even when the load itself is rejected.
         if (ld_ok) begin
            year  <= load_year;
            month <= load_month;
            day   <= load_day;
            doy   <= ld_doy;
         end else begin
            load_err <= 1'b1;
         end
      end else if (tick) begin
         if (day < cur_len) begin
            day <= day + 5'd1;
            doy <= doy + 9'd1;
         end else if (month < 4'd12) begin
            month <= month + 4'd1;
            day   <= 5'd1;
            doy   <= doy + 9'd1;
         end else begin
            month    <= 4'd1;
            day      <= 5'd1;
            doy      <= 9'd1;
            year     <= year + 1'b1;
            new_year <= 1'b1;
            if (year == {YEAR_W{1'b1}})
               year_wrap <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_calendar_date_counter.sv
// -----------------------------------------------------------------------------
// tb_calendar_date_counter
//
// Self-checking bench for calendar_date_counter. A calendar reference model
// (plain integer year/month/day, doy recomputed by summing month lengths)
// tracks the expected date; directed cases cover the documented scenarios and
// a randomized run mixes ticks, loads (valid and invalid) and resets.
// The external leap detector is emulated from the DUT's `year` output.
// -----------------------------------------------------------------------------
module tb_calendar_date_counter;

`ifdef LEAP_CENTURY_EN
   localparam int YW = 12;
`else
   localparam int YW = 11;
`endif
   localparam int YMAX = (1 << YW) - 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          tick  = 1'b0;
   logic          load  = 1'b0;
   logic [YW-1:0] load_year = '0;
   logic [3:0]    load_month = '0;
   logic [4:0]    load_day = '0;
   logic          leap4;
   logic [YW-1:0] year;
   logic [3:0]    month;
   logic [4:0]    day;
   logic [8:0]    doy;
   logic          new_year;
   logic          year_wrap;
   logic          load_err;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   int m_y, m_m, m_d;
   int e_ny, e_yw, e_le;

   always #5 clock = ~clock;

   // External divisible-by-4 detector driven by the registered year.
   assign leap4 = (year[1:0] == 2'b00);

   calendar_date_counter #(.YEAR_W(YW), .START_YEAR(2000)) dut (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick),
      .load       (load),
      .load_year  (load_year),
      .load_month (load_month),
      .load_day   (load_day),
      .leap4      (leap4),
      .year       (year),
      .month      (month),
      .day        (day),
      .doy        (doy),
      .new_year   (new_year),
      .year_wrap  (year_wrap),
      .load_err   (load_err)
   );

   function automatic bit is_leap(int y);
`ifdef LEAP_CENTURY_EN
      return (y % 400 == 0) || ((y % 4 == 0) && (y % 100 != 0));
`else
      return (y % 4 == 0);
`endif
   endfunction

   function automatic int mlen(int m, int y);
      int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      if (m < 1 || m > 12) return 0;
      if (m == 2 && is_leap(y)) return 29;
      return lens[m-1];
   endfunction

   function automatic int model_doy(int y, int m, int d);
      int s = d;
      for (int k = 1; k < m; k++) s += mlen(k, y);
      return s;
   endfunction

   task automatic check(string tag, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus, advance the model and compare every output.
   task automatic step(bit r, bit t, bit l, int ly, int lm, int ld);
      int ly_m;
      ly_m       = ly & YMAX;
      reset      = r;
      tick       = t;
      load       = l;
      load_year  = YW'(ly_m);
      load_month = 4'(lm);
      load_day   = 5'(ld);
      @(posedge clock);
      #1;
      e_ny = 0;
      e_yw = 0;
      e_le = 0;
      if (r) begin
         m_y = 2000; m_m = 1; m_d = 1;
      end else if (l) begin
         if (lm >= 1 && lm <= 12 && ld >= 1 && ld <= mlen(lm, ly_m)) begin
            m_y = ly_m; m_m = lm; m_d = ld;
         end else begin
            e_le = 1;
         end
      end else if (t) begin
         if (m_d < mlen(m_m, m_y)) begin
            m_d++;
         end else if (m_m < 12) begin
            m_m++; m_d = 1;
         end else begin
            m_m = 1; m_d = 1; e_ny = 1;
            if (m_y == YMAX) begin
               m_y = 0; e_yw = 1;
            end else begin
               m_y++;
            end
         end
      end
      check("year",      int'(year),      m_y);
      check("month",     int'(month),     m_m);
      check("day",       int'(day),       m_d);
      check("doy",       int'(doy),       model_doy(m_y, m_m, m_d));
      check("new_year",  int'(new_year),  e_ny);
      check("year_wrap", int'(year_wrap), e_yw);
      check("load_err",  int'(load_err),  e_le);
   endtask

   initial begin
      m_y = 2000; m_m = 1; m_d = 1;

      // Reset, then walk through Feb 29 of 2000 into March.
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);

      // Non-leap February and a rejected Feb 29 load.
      step(0, 0, 1, 2021, 2, 28);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 2021, 2, 29);
      step(0, 0, 0, 0, 0, 0);

      // Year rollover: new_year for exactly one cycle.
      step(0, 0, 1, 2021, 12, 31);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Year wrap at the maximum year.
      step(0, 0, 1, YMAX, 12, 31);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);

      // Load beats tick; rejected load still drops the tick; reset beats all.
      step(0, 1, 1, 2024, 7, 4);
      step(0, 1, 1, 2024, 13, 4);
      step(0, 1, 1, 2024, 4, 31);
      step(0, 1, 1, 2024, 4, 0);
      step(1, 1, 1, 2030, 5, 5);

      // Leap-year Dec 31 gives doy 366 before rolling.
      step(0, 0, 1, 2024, 12, 30);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);

`ifdef LEAP_CENTURY_EN
      step(0, 0, 1, 2100, 2, 28);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 2100, 2, 29);
      step(0, 0, 1, 2000, 2, 28);
      step(0, 1, 0, 0, 0, 0);
`endif

      // Randomized mix of ticks, loads and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bit r, t, l;
         int ly, lm, ld;
         r  = ($urandom_range(0, 199) == 0);
         l  = ($urandom_range(0, 9) == 0);
         t  = ($urandom_range(0, 3) != 0);
         ly = ($urandom_range(0, 3) == 0) ? YMAX - int'($urandom_range(0, 4))
                                          : int'($urandom_range(0, YMAX));
         if ($urandom_range(0, 2) == 0) begin
            lm = 12; ld = int'($urandom_range(29, 31));
         end else begin
            lm = int'($urandom_range(0, 15));
            ld = ($urandom_range(0, 1) == 0) ? int'($urandom_range(27, 31))
                                             : int'($urandom_range(0, 31));
         end
         step(r, t, l, ly, lm, ld);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
